// File: rtl/la_wb_master.sv
// -----------------------------------------------------------------------------
// la_wb_master
//
// Wishbone classic single-transfer initiator controlled by logic-analyzer
// command bits. The management side uses it to issue individual reads and
// writes to a Wishbone responder without involving the CPU. Only one transfer
// is in flight at a time.
//
// A transfer starts on a rising edge of cmd_go_i. The command fields are
// captured into the wbm_* outputs at that edge. cyc/stb then stay high until
// one of three things happens:
//   - the responder acks,
//   - the responder signals an error,
//   - TIMEOUT_CYCLES bus cycles pass with no response.
//
// Parameters:
//   TIMEOUT_CYCLES  bus cycles without ack/err before the transfer is aborted
//                   (1 .. 2**TO_W-1)
//   TO_W            width of the timeout counter
//
// Ports:
//   wb_clk_i, wb_rst_ni   clock; asynchronous active-low reset
//   cmd_go_i              start request, rising-edge triggered
//   cmd_we_i              1 = write, 0 = read
//   cmd_sel_i             byte selects
//   cmd_adr_i             transfer address
//   cmd_dat_i             write data
//   rsp_dat_o             data from the last successful read
//   busy_o                transfer in progress
//   done_o                one-cycle pulse at completion (ack, err or timeout)
//   err_o                 sticky: last transfer ended on err or timeout
//   txn_cnt_o             count of acked transfers, wraps at 255
//   wbm_*_o / wbm_*_i     Wishbone classic initiator port
// -----------------------------------------------------------------------------
`default_nettype none

module la_wb_master #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,

    input  logic        cmd_go_i,
    input  logic        cmd_we_i,
    input  logic [3:0]  cmd_sel_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,

    output logic [31:0] rsp_dat_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [7:0]  txn_cnt_o,

    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic [31:0] wbm_dat_i
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUS  = 1'b1
    } state_t;

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

    // -------------------------------------------------------------------------
    // State and datapath registers (q = current, d = next)
    // -------------------------------------------------------------------------
    state_t            state_q, state_d;
    logic              go_q;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              cyc_q, cyc_d;
    logic              we_q, we_d;
    logic [3:0]        sel_q, sel_d;
    logic [31:0]       adr_q, adr_d;
    logic [31:0]       dat_q, dat_d;
    logic [31:0]       rsp_q, rsp_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [7:0]        txn_q, txn_d;

    logic              start;
    logic [TO_W-1:0]   to_cnt_inc;
    logic              to_expired;

    // go_q resets high, so a go level still asserted when reset is released
    // does not count as a rising edge.
    assign start      = cmd_go_i & ~go_q;
    assign to_cnt_inc = to_cnt_q + TO_W'(1);
    // The counter is cleared at the start edge and advanced at every BUS
    // edge. It therefore reaches TO_LIMIT at the end of bus cycle number
    // TIMEOUT_CYCLES, which holds cyc high for exactly TIMEOUT_CYCLES cycles.
    assign to_expired = (to_cnt_inc == TO_LIMIT);

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here first gets a default (mostly "hold"),
        // so no path through the case leaves one unassigned. That is what keeps
        // this block from inferring latches.
        state_d  = state_q;
        to_cnt_d = to_cnt_q;
        cyc_d    = cyc_q;
        we_d     = we_q;
        sel_d    = sel_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        rsp_d    = rsp_q;
        done_d   = 1'b0;
        err_d    = err_q;
        txn_d    = txn_q;

        unique case (state_q)
            ST_IDLE: begin
                // ack/err arriving here are stray responses and are ignored.
                if (start) begin
                    we_d     = cmd_we_i;
                    sel_d    = cmd_sel_i;
                    adr_d    = cmd_adr_i;
                    dat_d    = cmd_dat_i;
                    cyc_d    = 1'b1;
                    err_d    = 1'b0;
                    to_cnt_d = '0;
                    state_d  = ST_BUS;
                end
            end

            ST_BUS: begin
                // Command fields are held. Further start edges are dropped
                // because only IDLE looks at start.
                to_cnt_d = to_cnt_inc;
                if (wbm_err_i) begin
                    // err has priority over a simultaneous ack.
                    cyc_d   = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (wbm_ack_i) begin
                    // An ack in the final allowed cycle still counts as success.
                    cyc_d   = 1'b0;
                    done_d  = 1'b1;
                    if (!we_q) begin
                        rsp_d = wbm_dat_i;
                    end
                    txn_d   = txn_q + 8'd1;
                    state_d = ST_IDLE;
                end else if (to_expired) begin
                    cyc_d   = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: the wide address/data registers are reset along with the control
    // registers, because every output has to read 0 from reset onwards.
    // Plain storage with no such visibility requirement would be left
    // unreset.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q  <= ST_IDLE;
            go_q     <= 1'b1;
            to_cnt_q <= '0;
            cyc_q    <= 1'b0;
            we_q     <= 1'b0;
            sel_q    <= '0;
            adr_q    <= '0;
            dat_q    <= '0;
            rsp_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            txn_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout. Every register then
            // updates from pre-edge values, whatever order the lines are in.
            state_q  <= state_d;
            go_q     <= cmd_go_i;
            to_cnt_q <= to_cnt_d;
            cyc_q    <= cyc_d;
            we_q     <= we_d;
            sel_q    <= sel_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            rsp_q    <= rsp_d;
            done_q   <= done_d;
            err_q    <= err_d;
            txn_q    <= txn_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Classic single transfers: stb always matches cyc, and busy is exactly
    // the interval in which the cycle is open.
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign busy_o    = cyc_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign rsp_dat_o = rsp_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign txn_cnt_o = txn_q;

endmodule

`default_nettype wire
